// File: rtl/counter_pkg.sv
// Shared definitions for the up-counter sequencer.
//   DEF_WIDTH  : default counter / limit width
//   DEF_REPS_W : default repeat-count width
//   state_t    : sequencer states
package counter_pkg;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_REPS_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        HOLD,
        DONE
    } state_t;

endpackage

// File: rtl/counter_ctrl.sv
// counter_ctrl: sequencer for an external up-counter.
// Accepts a (limit, repeats) command over valid/ready, clears the counter,
// lets it count 0..limit, wraps it, and repeats the programmed number of
// times. Supports pause (freeze) and abort (cancel and clear).
//
// Ports
//   clk, reset     rising-edge clock, synchronous active-high reset
//   start_valid    command valid; start_ready is high only in IDLE
//   cfg_limit      terminal count, sampled on accept
//   cfg_reps       number of wraps, sampled on accept (0 runs once)
//   pause          freeze counting while high
//   abort          cancel the current run (ignored in IDLE and DONE)
//   count          counter value fed back from the counter
//   cnt_en         counter increment enable
//   cnt_clr        counter synchronous clear (the counter gives clear priority)
//   busy           high in any state other than IDLE
//   wrap_pulse     one-cycle pulse on each terminal count
//   done           one-cycle pulse once all repeats have completed
//   reps_left      remaining wraps, including the current one
module counter_ctrl
    import counter_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int REPS_W = DEF_REPS_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [WIDTH-1:0]  cfg_limit,
    input  logic [REPS_W-1:0] cfg_reps,
    input  logic              pause,
    input  logic              abort,
    input  logic [WIDTH-1:0]  count,
    output logic              cnt_en,
    output logic              cnt_clr,
    output logic              busy,
    output logic              wrap_pulse,
    output logic              done,
    output logic [REPS_W-1:0] reps_left
);

    state_t            state_reg,  state_next;
    logic [WIDTH-1:0]  limit_reg,  limit_next;
    logic [REPS_W-1:0] reps_reg,   reps_next;
    logic              en_dec, clr_dec, wrap_dec;
    logic              terminal;

    // >= rather than == so a counter that starts out of range still wraps.
    assign terminal = (count >= limit_reg);

    always_comb begin
        state_next = state_reg;
        limit_next = limit_reg;
        reps_next  = reps_reg;
        en_dec     = 1'b0;
        clr_dec    = 1'b0;
        wrap_dec   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_valid) begin
                    limit_next = cfg_limit;
                    reps_next  = (cfg_reps == '0) ? REPS_W'(1) : cfg_reps;
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                clr_dec    = 1'b1;
                state_next = abort ? IDLE : RUN;
            end
            RUN: begin
                if (abort) begin
                    clr_dec    = 1'b1;
                    state_next = IDLE;
                end else if (pause) begin
                    // The pausing cycle neither counts nor checks terminal.
                    state_next = HOLD;
                end else begin
                    en_dec = 1'b1;
                    if (terminal) begin
                        wrap_dec = 1'b1;
                        clr_dec  = 1'b1;
                        // Last wrap leaves reps at 1 rather than reaching 0.
                        if (reps_reg == REPS_W'(1)) begin
                            state_next = DONE;
                        end else begin
                            reps_next = reps_reg - REPS_W'(1);
                        end
                    end
                end
            end
            HOLD: begin
                if (abort) begin
                    clr_dec    = 1'b1;
                    state_next = IDLE;
                end else if (!pause) begin
                    state_next = RUN;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            limit_reg <= '0;
            reps_reg  <= '0;
        end else begin
            state_reg <= state_next;
            limit_reg <= limit_next;
            reps_reg  <= reps_next;
        end
    end

    // Every output is forced low while reset is held, including the cycle
    // before the first clock edge when the state register is still unknown.
    assign start_ready = ~reset & (state_reg == IDLE);
    assign busy        = ~reset & (state_reg != IDLE);
    assign done        = ~reset & (state_reg == DONE);
    assign cnt_en      = ~reset & en_dec;
    assign cnt_clr     = ~reset & clr_dec;
    assign wrap_pulse  = ~reset & wrap_dec;
    assign reps_left   = reset ? '0 : reps_reg;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl paired with a simple enable/clear up-counter.
module tb_counter_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_valid;
    logic       start_ready;
    logic [3:0] cfg_limit;
    logic [3:0] cfg_reps;
    logic       pause;
    logic       abort;
    logic [3:0] count;
    logic       cnt_en;
    logic       cnt_clr;
    logic       busy;
    logic       wrap_pulse;
    logic       done;
    logic [3:0] reps_left;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [3:0] count;
        logic       en, clr, wrap, done, busy, ready, pause;
        logic [3:0] reps;
    } obs_t;
    obs_t obs[$];

    always #10 clk = ~clk;

    // Companion counter: clear has priority over enable.
    always @(posedge clk) begin
        if (reset || cnt_clr) count <= 4'd0;
        else if (cnt_en)      count <= count + 4'd1;
    end

    counter_ctrl #(.WIDTH(4), .REPS_W(4)) dut (
        .clk(clk), .reset(reset),
        .start_valid(start_valid), .start_ready(start_ready),
        .cfg_limit(cfg_limit), .cfg_reps(cfg_reps),
        .pause(pause), .abort(abort), .count(count),
        .cnt_en(cnt_en), .cnt_clr(cnt_clr), .busy(busy),
        .wrap_pulse(wrap_pulse), .done(done), .reps_left(reps_left)
    );

    // Issues one command in cycle 0 and records ncyc cycles of outputs.
    // pause is high for cycles [p_at, p_at+p_len), abort in cycle a_at,
    // and start_valid with junk config stays high for cycles 1..junk_end-1.
    task automatic run_cmd(input int lim, input int reps, input int ncyc,
                           input int p_at, input int p_len, input int a_at,
                           input int junk_end);
        obs_t o;
        obs.delete();
        $display("cmd limit=%0d reps=%0d cycles=%0d pause=%0d+%0d abort=%0d junk<%0d",
                 lim, reps, ncyc, p_at, p_len, a_at, junk_end);
        for (int i = 0; i < ncyc; i++) begin
            start_valid = (i == 0) || (i < junk_end);
            if (i == 0) begin
                cfg_limit = 4'(lim);
                cfg_reps  = 4'(reps);
            end else begin
                cfg_limit = 4'($urandom);
                cfg_reps  = 4'($urandom);
            end
            pause = (p_len > 0) && (i >= p_at) && (i < p_at + p_len);
            abort = (i == a_at);
            @(negedge clk);
            o.count = count;      o.en = cnt_en;     o.clr = cnt_clr;
            o.wrap  = wrap_pulse; o.done = done;     o.busy = busy;
            o.ready = start_ready; o.pause = pause;  o.reps = reps_left;
            obs.push_back(o);
            @(posedge clk); #1;
        end
        start_valid = 1'b0;
        pause       = 1'b0;
        abort       = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start_valid = 1'b1; pause = 1'b0; abort = 1'b0;
        cfg_limit = 4'd9; cfg_reps = 4'd2;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({start_ready, busy, cnt_en, cnt_clr, wrap_pulse, done, reps_left} !== 10'd0)
                $display("FAIL reset_outputs cycle=%0d got ready=%b busy=%b en=%b clr=%b wrap=%b done=%b reps=%0d want all 0",
                         i, start_ready, busy, cnt_en, cnt_clr, wrap_pulse, done, reps_left);
            else n_pass++;
        end
        @(posedge clk); #1;
        reset = 1'b0; start_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (start_ready !== 1'b1 || busy !== 1'b0 || reps_left !== 4'd0 ||
            {cnt_en, cnt_clr, wrap_pulse, done} !== 4'd0)
            $display("FAIL reset_release got ready=%b busy=%b reps=%0d en=%b clr=%b wrap=%b done=%b want ready=1 rest 0",
                     start_ready, busy, reps_left, cnt_en, cnt_clr, wrap_pulse, done);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    // Unpaused runs: count at cycle j (j>=2) is (j-2) mod (L+1).
    task automatic test_wraps();
        int lim_tab[4] = '{3, 0, 15, 6};
        int rep_tab[4] = '{2, 3, 1, 0};
        for (int t = 0; t < 10; t++) begin
            int L, Rin, R, D, e, er;
            if (t < 4) begin L = lim_tab[t]; Rin = rep_tab[t]; end
            else begin L = int'($urandom_range(15, 0)); Rin = int'($urandom_range(15, 0)); end
            R = (Rin == 0) ? 1 : Rin;
            D = 2 + R * (L + 1);
            run_cmd(L, Rin, D + 2, -1, 0, -1, 0);
            n_checks++;
            if (obs[0].ready !== 1'b1 || obs[0].busy !== 1'b0)
                $display("FAIL wraps_accept t=%0d got ready=%b busy=%b want 1/0", t, obs[0].ready, obs[0].busy);
            else n_pass++;
            n_checks++;
            if (obs[1].clr !== 1'b1 || obs[1].en !== 1'b0 || obs[1].busy !== 1'b1)
                $display("FAIL wraps_clear t=%0d got clr=%b en=%b busy=%b want 1/0/1", t, obs[1].clr, obs[1].en, obs[1].busy);
            else n_pass++;
            for (int j = 2; j < D; j++) begin
                e  = (j - 2) % (L + 1);
                er = R - (j - 2) / (L + 1);
                if (er < 1) er = 1;
                n_checks++;
                if (obs[j].count !== 4'(e) || obs[j].wrap !== (e == L) ||
                    obs[j].done !== 1'b0 || obs[j].reps !== 4'(er) || obs[j].en !== 1'b1)
                    $display("FAIL wraps_cycle L=%0d R=%0d idx=%0d got cnt=%0d wrap=%b done=%b reps=%0d en=%b want cnt=%0d wrap=%b done=0 reps=%0d en=1",
                             L, R, j, obs[j].count, obs[j].wrap, obs[j].done, obs[j].reps, obs[j].en, e, (e == L), er);
                else n_pass++;
            end
            n_checks++;
            if (obs[D].done !== 1'b1 || obs[D].count !== 4'd0 || obs[D].reps !== 4'd1)
                $display("FAIL wraps_done L=%0d R=%0d idx=%0d got done=%b cnt=%0d reps=%0d want 1/0/1",
                         L, R, D, obs[D].done, obs[D].count, obs[D].reps);
            else n_pass++;
            n_checks++;
            if (obs[D+1].done !== 1'b0 || obs[D+1].busy !== 1'b0 || obs[D+1].ready !== 1'b1)
                $display("FAIL wraps_idle L=%0d R=%0d got done=%b busy=%b ready=%b want 0/0/1",
                         L, R, obs[D+1].done, obs[D+1].busy, obs[D+1].ready);
            else n_pass++;
        end
    endtask

    // A pause window starting in RUN costs len+1 cycles: the paused RUN
    // cycle, the held cycles, and the HOLD cycle in which pause drops.
    task automatic test_pause();
        for (int t = 0; t < 6; t++) begin
            int L, R, p, len, D, e0, nwrap, ndone, bad_en, bad_wc;
            if (t == 0) begin L = 5; R = 1; p = 3; len = 2; end
            else begin
                L = int'($urandom_range(9, 0)); R = int'($urandom_range(3, 1));
                p = int'($urandom_range(1 + R * (L + 1), 2)); len = int'($urandom_range(4, 1));
            end
            D  = 2 + R * (L + 1) + len + 1;
            e0 = (p - 2) % (L + 1);
            run_cmd(L, R, D + 2, p, len, -1, 0);
            nwrap = 0; ndone = 0; bad_en = 0; bad_wc = 0;
            foreach (obs[i]) begin
                if (obs[i].wrap) begin nwrap++; if (obs[i].count !== 4'(L)) bad_wc++; end
                if (obs[i].done) ndone++;
                if (obs[i].pause && obs[i].en !== 1'b0) bad_en++;
            end
            n_checks++;
            if (obs[D].done !== 1'b1 || ndone != 1)
                $display("FAIL pause_done L=%0d R=%0d p=%0d len=%0d got done@D=%b pulses=%0d want 1/1", L, R, p, len, obs[D].done, ndone);
            else n_pass++;
            n_checks++;
            if (nwrap != R || bad_wc != 0)
                $display("FAIL pause_wraps L=%0d got wraps=%0d badcnt=%0d want %0d/0", L, nwrap, bad_wc, R);
            else n_pass++;
            n_checks++;
            if (bad_en != 0) $display("FAIL pause_enable got en-while-paused=%0d want 0", bad_en);
            else n_pass++;
            for (int i = p; i <= p + len + 1; i++) begin
                n_checks++;
                if (obs[i].count !== 4'(e0))
                    $display("FAIL pause_hold idx=%0d got cnt=%0d want %0d", i, obs[i].count, e0);
                else n_pass++;
            end
            n_checks++;
            if (obs[D+1].busy !== 1'b0) $display("FAIL pause_idle got busy=%b want 0", obs[D+1].busy);
            else n_pass++;
        end
    endtask

    task automatic test_abort();
        for (int t = 0; t < 7; t++) begin
            int L, R, a, p, len, ndone;
            p = -1; len = 0;
            if (t == 0) begin L = 7; R = 1; a = 4; end
            else if (t == 1) begin L = 7; R = 2; a = 5; p = 3; len = 5; end  // abort in HOLD
            else begin
                L = int'($urandom_range(9, 0)); R = int'($urandom_range(3, 1));
                a = int'($urandom_range(1 + R * (L + 1), 1));
            end
            run_cmd(L, R, a + 3, p, len, a, 0);
            n_checks++;
            if (obs[a].clr !== 1'b1 || obs[a].en !== 1'b0 || obs[a].wrap !== 1'b0 || obs[a].busy !== 1'b1)
                $display("FAIL abort_cycle L=%0d a=%0d got clr=%b en=%b wrap=%b busy=%b want 1/0/0/1",
                         L, a, obs[a].clr, obs[a].en, obs[a].wrap, obs[a].busy);
            else n_pass++;
            if (p < 0 && a >= 2) begin
                n_checks++;
                if (obs[a].count !== 4'((a - 2) % (L + 1)))
                    $display("FAIL abort_count a=%0d got cnt=%0d want %0d", a, obs[a].count, (a - 2) % (L + 1));
                else n_pass++;
            end
            n_checks++;
            if (obs[a+1].busy !== 1'b0 || obs[a+1].ready !== 1'b1 || obs[a+1].count !== 4'd0)
                $display("FAIL abort_idle got busy=%b ready=%b cnt=%0d want 0/1/0",
                         obs[a+1].busy, obs[a+1].ready, obs[a+1].count);
            else n_pass++;
            ndone = 0;
            foreach (obs[i]) if (obs[i].done) ndone++;
            n_checks++;
            if (ndone != 0) $display("FAIL abort_nodone got done pulses=%0d want 0", ndone);
            else n_pass++;
        end
    endtask

    // Abort in IDLE (with the accepted command) and in DONE changes nothing.
    task automatic test_abort_ignored();
        int L = 4, R = 2, D, nwrap;
        D = 2 + R * (L + 1);
        for (int t = 0; t < 2; t++) begin
            run_cmd(L, R, D + 2, -1, 0, (t == 0) ? 0 : D, 0);
            nwrap = 0;
            foreach (obs[i]) if (obs[i].wrap) nwrap++;
            n_checks++;
            if (obs[D].done !== 1'b1 || nwrap != R || obs[D+1].ready !== 1'b1)
                $display("FAIL abort_ignored t=%0d got done=%b wraps=%0d ready=%b want 1/%0d/1",
                         t, obs[D].done, nwrap, obs[D+1].ready, R);
            else n_pass++;
        end
    endtask

    // start_valid held high through the whole run must not be accepted.
    task automatic test_busy_ignore();
        int L, R = 2, D, bad, nwrap;
        L = int'($urandom_range(6, 1));
        D = 2 + R * (L + 1);
        run_cmd(L, R, D + 2, -1, 0, -1, D + 1);
        bad = 0; nwrap = 0;
        for (int i = 1; i <= D; i++) begin
            if (obs[i].ready !== 1'b0 || obs[i].busy !== 1'b1) bad++;
            if (obs[i].wrap) nwrap++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL busy_ready got bad cycles=%0d want 0", bad);
        else n_pass++;
        n_checks++;
        if (obs[D].done !== 1'b1 || nwrap != R)
            $display("FAIL busy_timing got done=%b wraps=%0d want 1/%0d", obs[D].done, nwrap, R);
        else n_pass++;
        n_checks++;
        if (obs[D+1].busy !== 1'b0 || obs[D+1].ready !== 1'b1)
            $display("FAIL busy_idle got busy=%b ready=%b want 0/1", obs[D+1].busy, obs[D+1].ready);
        else n_pass++;
    endtask

    // A new command issued in the IDLE cycle straight after DONE.
    task automatic test_back_to_back();
        int L1 = 2, R1 = 2, L2 = 1, R2 = 3, D1, D2;
        D1 = 2 + R1 * (L1 + 1);
        D2 = 2 + R2 * (L2 + 1);
        run_cmd(L1, R1, D1 + 1, -1, 0, -1, 0);
        n_checks++;
        if (obs[D1].done !== 1'b1) $display("FAIL b2b_first got done=%b want 1", obs[D1].done);
        else n_pass++;
        run_cmd(L2, R2, D2 + 2, -1, 0, -1, 0);
        n_checks++;
        if (obs[0].ready !== 1'b1 || obs[1].clr !== 1'b1 || obs[2].count !== 4'd0 || obs[2].reps !== 4'(R2))
            $display("FAIL b2b_start got ready=%b clr=%b cnt=%0d reps=%0d want 1/1/0/%0d",
                     obs[0].ready, obs[1].clr, obs[2].count, obs[2].reps, R2);
        else n_pass++;
        n_checks++;
        if (obs[D2].done !== 1'b1 || obs[2 + L2].wrap !== 1'b1)
            $display("FAIL b2b_second got done=%b firstwrap=%b want 1/1", obs[D2].done, obs[2 + L2].wrap);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_wraps();
        test_pause();
        test_abort();
        test_abort_ignored();
        test_busy_ignore();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
